xy_route_arbiter: RTL
=====================

XY_ROUTE_ARBITER -- requirements
Module: xy_route_arbiter

Interface
REQ-001 Parameters: PORT_N, default 5, number of router ports; DATA_W, default 8, flit width; ROW_ADDR_W, default 2, destination row field width; COL_ADDR_W, default 2, destination column field width; ROW_CORD, default 0, this router's row; COL_CORD, default 0, this router's column.
REQ-002 Single clock; reset is synchronous and active-high.
REQ-003 clk_i  input  1  clock, all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 vld_input_i  input  PORT_N  per-port "head flit valid", driven by the switch control unit.
REQ-006 data_i  input  PORT_N*DATA_W  head flit of each input buffer; port p occupies bits [p*DATA_W +: DATA_W].
REQ-007 wr_en_i  input  PORT_N  per-output write strobe from the control unit; marks a completed transfer.
REQ-008 mux_in_sel_o  output  clog2(PORT_N)  granted input port.
REQ-009 mux_out_sel_o  output  clog2(PORT_N)  routed output port for the granted input.
REQ-010 grant_vld_o  output  1  high while a grant is held.

Function
REQ-011 Port numbering SHALL be 0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST.
REQ-012 Flit destination fields SHALL be: dest_col = data[COL_ADDR_W-1:0]; dest_row = data[COL_ADDR_W +: ROW_ADDR_W]; unsigned compare.
REQ-013 XY routing SHALL be: dest_col>COL_CORD -> EAST; dest_col<COL_CORD -> WEST; else dest_row>ROW_CORD -> SOUTH; dest_row<ROW_CORD -> NORTH; else LOCAL.
REQ-014 FSM states SHALL be IDLE and GRANT.
REQ-015 In IDLE with vld_input_i nonzero, the block SHALL select the first valid port at or after rr_ptr, scanning upward with wrap modulo PORT_N.
REQ-016 On that edge it SHALL register mux_in_sel_o = selected port and mux_out_sel_o = route(data_i[selected]), and enter GRANT; grant_vld_o rises one cycle after vld is seen.
REQ-017 In IDLE with vld_input_i zero, the FSM SHALL stay in IDLE and the select outputs SHALL hold their values.
REQ-018 In GRANT, the select outputs SHALL be frozen regardless of data_i changes.
REQ-019 In GRANT, when wr_en_i[mux_out_sel_o]=1 the FSM SHALL go to IDLE and rr_ptr SHALL become (mux_in_sel_o+1) mod PORT_N.
REQ-020 In GRANT, when vld_input_i[mux_in_sel_o]=0 and no write occurs, the FSM SHALL go to IDLE with rr_ptr unchanged (abort).
REQ-021 wr_en_i bits other than mux_out_sel_o SHALL be ignored.
REQ-022 If a write and a valid drop occur in the same cycle, the write SHALL take precedence (rr_ptr advances).
REQ-023 There SHALL be one IDLE bubble cycle between consecutive grants; no back-to-back re-arbitration.
REQ-024 grant_vld_o SHALL be 1 exactly in GRANT.
REQ-025 U-turn routes (out == in, non-LOCAL) SHALL be routed unchanged; no error reporting.

Reset
REQ-026 On rst_i=1 at a clock edge: state=IDLE, rr_ptr=0, mux_in_sel_o=0, mux_out_sel_o=0, grant_vld_o=0.
REQ-027 Reset asserted in GRANT SHALL drop the grant in the following cycle with no pointer update.

Structure
REQ-028 Port index constants (LOCAL..WEST) and the FSM state encoding SHALL live in a shared package used by the switch.
REQ-029 XY route computation SHALL be a combinational sub-module, xy_route_calc, instantiated once on the selected input's flit.
REQ-030 Formal assertions SHALL be included under FORMAL: grant_vld_o implies vld_input_i[mux_in_sel_o] held since grant or abort next cycle; selects stable while in GRANT.

Verification (ROW_CORD=1, COL_CORD=1)
REQ-031 Route table: dest (r1,c2)->2; (r1,c0)->4; (r0,c1)->1; (r2,c1)->3; (r1,c1)->0; (r0,c0)->4 (X first).
REQ-032 Single grant: vld_input_i=00001, dest (1,2) -> next cycle grant_vld_o=1, in=0, out=2; pulse wr_en_i=00100 -> next cycle IDLE, rr_ptr=1.
REQ-033 Fairness: vld_input_i=11111 held, each grant completed by wr_en_i -> grant order 0,1,2,3,4,0.
REQ-034 Stall: granted, wr_en_i=0 for 10 cycles while data_i toggles -> selects and grant_vld_o unchanged.
REQ-035 Abort and reset: drop vld_input_i[in] mid-GRANT -> IDLE, rr_ptr unchanged; rst_i mid-GRANT -> all outputs 0, rr_ptr=0.

Source files
------------

// File: rtl/xy_route_arbiter_pkg.sv
// Shared port numbering and arbiter state encoding for the XY router switch.
package xy_route_arbiter_pkg;

    localparam int unsigned PORT_LOCAL = 0;
    localparam int unsigned PORT_NORTH = 1;
    localparam int unsigned PORT_EAST  = 2;
    localparam int unsigned PORT_SOUTH = 3;
    localparam int unsigned PORT_WEST  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/xy_route_arbiter_route_calc.sv
// Combinational dimension-ordered (X then Y) output port selection.
module xy_route_calc
    import xy_route_arbiter_pkg::*;
#(
    parameter int ROW_ADDR_W = 2,
    parameter int COL_ADDR_W = 2,
    parameter int ROW_CORD   = 0,
    parameter int COL_CORD   = 0,
    parameter int SEL_W      = 3
) (
    input  logic [ROW_ADDR_W+COL_ADDR_W-1:0] addr_i,
    output logic [SEL_W-1:0]                 port_o
);

    localparam logic [ROW_ADDR_W-1:0] MY_ROW = ROW_ADDR_W'(ROW_CORD);
    localparam logic [COL_ADDR_W-1:0] MY_COL = COL_ADDR_W'(COL_CORD);

    logic [ROW_ADDR_W-1:0] dest_row;
    logic [COL_ADDR_W-1:0] dest_col;

    assign dest_col = addr_i[COL_ADDR_W-1:0];
    assign dest_row = addr_i[COL_ADDR_W +: ROW_ADDR_W];

    always_comb begin
        port_o = SEL_W'(PORT_LOCAL);
        if (dest_col > MY_COL) begin
            port_o = SEL_W'(PORT_EAST);
        end else if (dest_col < MY_COL) begin
            port_o = SEL_W'(PORT_WEST);
        end else if (dest_row > MY_ROW) begin
            port_o = SEL_W'(PORT_SOUTH);
        end else if (dest_row < MY_ROW) begin
            port_o = SEL_W'(PORT_NORTH);
        end
    end

endmodule

// File: rtl/xy_route_arbiter.sv
// Round-robin input arbiter with XY route lookup for one router switch.
module xy_route_arbiter
    import xy_route_arbiter_pkg::*;
#(
    parameter int PORT_N     = 5,
    parameter int DATA_W     = 8,
    parameter int ROW_ADDR_W = 2,
    parameter int COL_ADDR_W = 2,
    parameter int ROW_CORD   = 0,
    parameter int COL_CORD   = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [PORT_N-1:0]          vld_input_i,
    input  logic [PORT_N*DATA_W-1:0]   data_i,
    input  logic [PORT_N-1:0]          wr_en_i,
    output logic [$clog2(PORT_N)-1:0]  mux_in_sel_o,
    output logic [$clog2(PORT_N)-1:0]  mux_out_sel_o,
    output logic                       grant_vld_o
);

    localparam int SEL_W = $clog2(PORT_N);
    localparam int AW    = ROW_ADDR_W + COL_ADDR_W;

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] in_sel_q, in_sel_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;

    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] route;
    logic [AW-1:0]    addr_a [PORT_N];
    logic             unused_data;

    // Only the address field of each head flit matters for arbitration.
    assign unused_data = ^data_i;

    always_comb begin
        for (int p = 0; p < PORT_N; p++) begin
            addr_a[p] = data_i[p*DATA_W +: AW];
        end
    end

    always_comb begin
        int               idx_i;
        logic [SEL_W-1:0] idx;
        logic             found;
        pick  = rr_ptr_q;
        found = 1'b0;
        idx_i = 0;
        idx   = '0;
        for (int i = 0; i < PORT_N; i++) begin
            idx_i = int'(rr_ptr_q) + i;
            if (idx_i >= PORT_N) begin
                idx_i = idx_i - PORT_N;
            end
            idx = SEL_W'(idx_i);
            if (!found && vld_input_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    xy_route_calc #(
        .ROW_ADDR_W (ROW_ADDR_W),
        .COL_ADDR_W (COL_ADDR_W),
        .ROW_CORD   (ROW_CORD),
        .COL_CORD   (COL_CORD),
        .SEL_W      (SEL_W)
    ) u_route (
        .addr_i (addr_a[pick]),
        .port_o (route)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        in_sel_d  = in_sel_q;
        out_sel_d = out_sel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|vld_input_i) begin
                    in_sel_d  = pick;
                    out_sel_d = route;
                    state_d   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A completed write wins over a simultaneous valid drop.
                if (wr_en_i[out_sel_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (in_sel_q == SEL_W'(PORT_N - 1)) ?
                               '0 : in_sel_q + 1'b1;
                end else if (!vld_input_i[in_sel_q]) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            in_sel_q  <= '0;
            out_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            in_sel_q  <= in_sel_d;
            out_sel_q <= out_sel_d;
        end
    end

    assign mux_in_sel_o  = in_sel_q;
    assign mux_out_sel_o = out_sel_q;
    assign grant_vld_o   = (state_q == ST_GRANT);

`ifdef FORMAL
    a_abort: assert property (@(posedge clk_i) disable iff (rst_i)
        (grant_vld_o && !wr_en_i[out_sel_q] && !vld_input_i[in_sel_q])
        |=> !grant_vld_o);
    a_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (grant_vld_o && $past(grant_vld_o))
        |-> ($stable(in_sel_q) && $stable(out_sel_q)));
`endif

endmodule
